// File: rtl/atpg_entry_ctl.sv
// atpg_entry_ctl: TST/SCL/SDA keyed test-mode entry controller gating ATPG scan configuration
module atpg_entry_ctl #(
  parameter int              KEY_W    = 16,
  parameter logic [KEY_W-1:0] KEY     = 16'hA5C3,
  parameter int              SYNC_STG = 2,
  parameter int              TMO_W    = 8,
  parameter int              MAX_FAIL = 3
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       tst_pin,
  input  logic       scl_pin,
  input  logic       sda_pin,
  output logic       atpg_mode,
  output logic       entry_err,
  output logic [1:0] fail_cnt,
  output logic       perm_lock,
  output logic [2:0] state
);
  localparam int CW = $clog2(KEY_W + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SHIFT = 3'd1, CHECK = 3'd2, ATPG = 3'd3, LOCK = 3'd4} state_e;
  state_e state_q, state_d;
  logic [SYNC_STG-1:0] tst_sync_q, tst_sync_d, scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic tst_prev_q, scl_prev_q;
  logic [KEY_W-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [1:0] fail_q, fail_d, fail_inc;
  logic lock_q, lock_d, err_q, err_d, atpg_q, atpg_d;
  logic tst_s, scl_s, sda_s, tst_rise, tst_fall, scl_rise;
  assign tst_sync_d = {tst_sync_q[SYNC_STG-2:0], tst_pin};
  assign scl_sync_d = {scl_sync_q[SYNC_STG-2:0], scl_pin};
  assign sda_sync_d = {sda_sync_q[SYNC_STG-2:0], sda_pin};
  assign tst_s = tst_sync_q[SYNC_STG-1];
  assign scl_s = scl_sync_q[SYNC_STG-1];
  assign sda_s = sda_sync_q[SYNC_STG-1];
  assign tst_rise = tst_s & ~tst_prev_q;
  assign tst_fall = ~tst_s & tst_prev_q;
  assign scl_rise = scl_s & ~scl_prev_q;
  assign fail_inc = fail_q + {1'b0, ~&fail_q};
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    fail_d = fail_q;
    err_d = 1'b0;
    case (state_q)
      IDLE:
        if (tst_rise && !lock_q) begin
          state_d = SHIFT;
          sr_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end
      SHIFT:
        // abort beats a completed key, an SCL edge and a timeout alike
        if (tst_fall) state_d = IDLE;
        else if (cnt_q == CW'(KEY_W)) state_d = CHECK;
        else if (scl_rise) begin
          sr_d = {sr_q[KEY_W-2:0], sda_s};
          cnt_d = cnt_q + CW'(1);
          tmr_d = '0;
        end else if (&tmr_q) begin
          state_d = LOCK;
          err_d = 1'b1;
          fail_d = fail_inc;
        end else tmr_d = tmr_q + TMO_W'(1);
      CHECK:
        if (tst_fall) state_d = IDLE;
        else if (sr_q == KEY) begin
          state_d = ATPG;
          fail_d = '0;
        end else begin
          state_d = LOCK;
          err_d = 1'b1;
          fail_d = fail_inc;
        end
      ATPG, LOCK: state_d = tst_fall ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
    lock_d = lock_q | (fail_d >= 2'(MAX_FAIL));
    atpg_d = state_d == ATPG;
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tst_sync_q <= '0;
      scl_sync_q <= '0;
      sda_sync_q <= '0;
      tst_prev_q <= 1'b0;
      scl_prev_q <= 1'b0;
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      fail_q <= '0;
      lock_q <= 1'b0;
      err_q <= 1'b0;
      atpg_q <= 1'b0;
    end else begin
      tst_sync_q <= tst_sync_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      tst_prev_q <= tst_s;
      scl_prev_q <= scl_s;
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      fail_q <= fail_d;
      lock_q <= lock_d;
      err_q <= err_d;
      atpg_q <= atpg_d;
    end
  end
  assign atpg_mode = atpg_q;
  assign entry_err = err_q;
  assign fail_cnt = fail_q;
  assign perm_lock = lock_q;
  assign state = state_q;
endmodule

// File: tb/tb_atpg_entry_ctl.sv
// tb_atpg_entry_ctl: randomized keyed-entry scenarios against an attempt-level outcome model
module tb_atpg_entry_ctl;
  localparam logic [15:0] KEY = 16'hA5C3;
  logic clk = 0, rstz = 0, tst_pin = 0, scl_pin = 0, sda_pin = 0;
  logic atpg_mode, entry_err, perm_lock;
  logic [1:0] fail_cnt;
  logic [2:0] state;
  int vectors = 0, errors = 0;
  int m_fail = 0;
  bit m_lock = 0, m_atpg = 0;

  atpg_entry_ctl dut (
    .clk(clk), .rstz(rstz), .tst_pin(tst_pin), .scl_pin(scl_pin), .sda_pin(sda_pin),
    .atpg_mode(atpg_mode), .entry_err(entry_err), .fail_cnt(fail_cnt),
    .perm_lock(perm_lock), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  // a failed attempt bumps the saturating counter and may lock entry for good
  task automatic model_fail();
    m_fail = (m_fail < 3) ? m_fail + 1 : 3;
    m_lock = m_lock || (m_fail >= 3);
  endtask

  task automatic do_reset();
    tst_pin = 0;
    scl_pin = 0;
    rstz = 0;
    repeat (2) @(negedge clk);
    rstz = 1;
    @(negedge clk);
    m_fail = 0;
    m_lock = 0;
    m_atpg = 0;
  endtask

  task automatic send_bits(input logic [15:0] k, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      scl_pin = 0;
      sda_pin = k[15-i];
      repeat (gap) @(negedge clk);
      scl_pin = 1;
      if (i != n - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic start_attempt();
    tst_pin = 0;
    repeat (4) @(negedge clk);
    tst_pin = 1;
    repeat (4) @(negedge clk);
    vectors++;
    if (state !== (m_lock ? 3'd0 : 3'd1)) begin
      errors++;
      $display("FAIL start_state: got %0d exp %0d", state, m_lock ? 0 : 1);
    end
  endtask

  task automatic attempt(input logic [15:0] k, input int gap);
    start_attempt();
    send_bits(k, 16, gap);
    repeat (4) @(negedge clk);
    vectors++;
    if (atpg_mode !== 1'b0 || entry_err !== 1'b0) begin
      errors++;
      $display("FAIL early_result: got atpg=%0b err=%0b exp 0 0", atpg_mode, entry_err);
    end
    @(negedge clk);
    if (m_lock) begin
      vectors++;
      if (state !== 3'd0 || atpg_mode !== 1'b0 || perm_lock !== 1'b1) begin
        errors++;
        $display("FAIL locked_attempt: got state=%0d atpg=%0b lock=%0b exp 0 0 1", state, atpg_mode, perm_lock);
      end
      m_atpg = 0;
    end else if (k == KEY) begin
      m_fail = 0;
      m_atpg = 1;
      vectors++;
      if (atpg_mode !== 1'b1 || state !== 3'd3 || fail_cnt !== 2'd0 || entry_err !== 1'b0) begin
        errors++;
        $display("FAIL good_key: got atpg=%0b state=%0d fail=%0d err=%0b exp 1 3 0 0", atpg_mode, state, fail_cnt, entry_err);
      end
    end else begin
      model_fail();
      m_atpg = 0;
      vectors++;
      if (entry_err !== 1'b1 || state !== 3'd4 || fail_cnt !== 2'(m_fail)) begin
        errors++;
        $display("FAIL bad_key: got err=%0b state=%0d fail=%0d exp 1 4 %0d", entry_err, state, fail_cnt, m_fail);
      end
      @(negedge clk);
      vectors++;
      if (entry_err !== 1'b0 || perm_lock !== m_lock) begin
        errors++;
        $display("FAIL bad_key_after: got err=%0b lock=%0b exp 0 %0b", entry_err, perm_lock, m_lock);
      end
    end
    scl_pin = 0;
  endtask

  task automatic exit_tst();
    tst_pin = 0;
    repeat (2) @(negedge clk);
    if (m_atpg) begin
      vectors++;
      if (atpg_mode !== 1'b1) begin
        errors++;
        $display("FAIL exit_hold: got atpg=%0b exp 1", atpg_mode);
      end
    end
    @(negedge clk);
    vectors++;
    if (atpg_mode !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL exit: got atpg=%0b state=%0d exp 0 0", atpg_mode, state);
    end
    m_atpg = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (state !== 3'd0 || atpg_mode !== 1'b0 || entry_err !== 1'b0 || fail_cnt !== 2'd0 || perm_lock !== 1'b0) begin
      errors++;
      $display("FAIL reset: got state=%0d atpg=%0b err=%0b fail=%0d lock=%0b exp all 0",
               state, atpg_mode, entry_err, fail_cnt, perm_lock);
    end
    rstz = 1;
    @(negedge clk);
  endtask

  task automatic test_entry();
    attempt(KEY, 4);
    exit_tst();
  endtask

  task automatic test_wrong_key();
    attempt(16'hA5C2, 4);
    exit_tst();
    attempt(KEY, 4);
    exit_tst();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit found = 0;
    start_attempt();
    send_bits(KEY, 5, 4);
    while (n < 400 && !found) begin
      @(negedge clk);
      n++;
      if (entry_err === 1'b1) found = 1;
    end
    model_fail();
    vectors++;
    if (!found || n < 255 || n > 262) begin
      errors++;
      $display("FAIL timeout_delay: got found=%0b cycles=%0d exp 1 255..262", found, n);
    end
    @(negedge clk);
    vectors++;
    if (entry_err !== 1'b0 || state !== 3'd4 || fail_cnt !== 2'(m_fail)) begin
      errors++;
      $display("FAIL timeout_state: got err=%0b state=%0d fail=%0d exp 0 4 %0d", entry_err, state, fail_cnt, m_fail);
    end
    scl_pin = 0;
    exit_tst();
  endtask

  task automatic test_perm_lock();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      attempt(KEY ^ 16'(1 << i), 4);
      exit_tst();
    end
    vectors++;
    if (perm_lock !== 1'b1 || fail_cnt !== 2'd3) begin
      errors++;
      $display("FAIL perm_lock: got lock=%0b fail=%0d exp 1 3", perm_lock, fail_cnt);
    end
    attempt(KEY, 4);
    exit_tst();
    do_reset();
    vectors++;
    if (perm_lock !== 1'b0 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL lock_clear: got lock=%0b fail=%0d exp 0 0", perm_lock, fail_cnt);
    end
    attempt(KEY, 4);
    exit_tst();
  endtask

  task automatic test_abort();
    bit bad = 0;
    attempt(16'h1234, 4);
    exit_tst();
    start_attempt();
    send_bits(KEY, 15, 4);
    repeat (4) @(negedge clk);
    scl_pin = 0;
    sda_pin = KEY[0];
    repeat (4) @(negedge clk);
    scl_pin = 1;
    tst_pin = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (entry_err !== 1'b0 || state === 3'd2 || state === 3'd3 || atpg_mode !== 1'b0) bad = 1;
    end
    vectors++;
    if (bad || state !== 3'd0 || fail_cnt !== 2'(m_fail)) begin
      errors++;
      $display("FAIL abort: got bad=%0b state=%0d fail=%0d exp 0 0 %0d", bad, state, fail_cnt, m_fail);
    end
    scl_pin = 0;
  endtask

  task automatic test_reset_in_atpg();
    attempt(KEY, 3);
    rstz = 0;
    #2;
    vectors++;
    if (atpg_mode !== 1'b0 || state !== 3'd0 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got atpg=%0b state=%0d fail=%0d exp 0 0 0", atpg_mode, state, fail_cnt);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      logic [15:0] k;
      int gap;
      k = ($urandom_range(0, 1) == 1) ? KEY : 16'($urandom);
      gap = $urandom_range(2, 6);
      attempt(k, gap);
      exit_tst();
      if (m_lock) begin
        attempt(KEY, gap);
        exit_tst();
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_wrong_key();
    test_timeout();
    test_perm_lock();
    test_abort();
    test_reset_in_atpg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
